// File: rtl/wts_tone_generator_mc_pkg.sv
// Shared definitions for the wave-table tone generator.
//   WL_32 / WL_64 / WL_128 : wave length mode encodings (mode 3 aliases WL_128)
//   wave_len_log2()        : log2 of the wave length for a mode, clamped to the
//                            address width
package wts_pkg;

  localparam logic [1:0] WL_32  = 2'd0;
  localparam logic [1:0] WL_64  = 2'd1;
  localparam logic [1:0] WL_128 = 2'd2;

  // L = 5 + mode; the unused mode 3 behaves like WL_128, and L never exceeds
  // the wave address width.
  function automatic logic [3:0] wave_len_log2(input logic [1:0] mode,
                                               input logic [3:0] addr_w);
    logic [1:0] m;
    logic [3:0] l;
    m = (mode == 2'd3) ? WL_128 : mode;
    l = 4'd5 + {2'b00, m};
    if (l > addr_w) l = addr_w;
    return l;
  endfunction

endpackage

// File: rtl/wts_tone_generator_mc_if.sv
// Bus between the tone generator and its register block / wave memory / mixer.
//   master : drives enable, register values and key_on pulses
//   slave  : the generator; returns the registered per-slot result bus
// Valid semantics: slot_valid is a one-cycle qualifier with no back-pressure.
// When high, slot_ch / wave_address / half_timing describe the slot serviced
// in the previous cycle; when low those three hold stale values and must be
// ignored. active is meaningful every cycle.
interface wts_tone_generator_mc_if #(
  parameter int NUM_CH = 5,
  parameter int FREQ_W = 12,
  parameter int ADDR_W = 7
);
  localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                       enable;
  logic [NUM_CH*FREQ_W-1:0]   reg_frequency_count;
  logic [NUM_CH*2-1:0]        reg_wave_length;
  logic [NUM_CH-1:0]          reg_oneshot;
  logic [NUM_CH-1:0]          key_on;

  logic                       slot_valid;
  logic [SLOT_W-1:0]          slot_ch;
  logic [ADDR_W-1:0]          wave_address;
  logic                       half_timing;
  logic [NUM_CH-1:0]          active;

  modport master (
    output enable, reg_frequency_count, reg_wave_length, reg_oneshot, key_on,
    input  slot_valid, slot_ch, wave_address, half_timing, active
  );

  modport slave (
    input  enable, reg_frequency_count, reg_wave_length, reg_oneshot, key_on,
    output slot_valid, slot_ch, wave_address, half_timing, active
  );
endinterface

// File: rtl/wts_tone_generator_mc_step.sv
// Combinational next-state of one channel for the slot in which it is serviced.
//   cnt_i/addr_i/stopped_i : current channel state
//   freq_i/mode_i/oneshot_i: channel register values
//   key_on_i               : restart request (pending or same-cycle pulse)
//   cnt_o/addr_o/stopped_o : state to write back
//   wave_address_o         : masked address of the sample played in this slot
//   half_timing_o          : half-wave boundary crossed in this slot
module wts_tone_step
  import wts_pkg::*;
#(
  parameter int FREQ_W = 12,
  parameter int ADDR_W = 7
) (
  input  logic [FREQ_W-1:0] cnt_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [FREQ_W-1:0] freq_i,
  input  logic [1:0]        mode_i,
  input  logic              oneshot_i,
  input  logic              key_on_i,
  input  logic              stopped_i,
  output logic [FREQ_W-1:0] cnt_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] wave_address_o,
  output logic              half_timing_o,
  output logic              stopped_o
);
  localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

  logic [3:0]        len;
  logic [ADDR_W:0]   lmask_w;
  logic [ADDR_W-1:0] lmask;
  logic [ADDR_W-1:0] hmask;
  logic              at_end;
  logic              end_of_wave;

  always_comb begin
    len         = wave_len_log2(mode_i, 4'(ADDR_W));
    lmask_w     = (ONE_W << len) - ONE_W;
    lmask       = lmask_w[ADDR_W-1:0];
    hmask       = lmask >> 1;
    at_end      = (cnt_i == '0);
    end_of_wave = at_end && ((addr_i & lmask) == lmask);

    cnt_o          = cnt_i;
    addr_o         = addr_i;
    stopped_o      = stopped_i;
    half_timing_o  = 1'b0;
    wave_address_o = addr_i & lmask;

    if (key_on_i) begin
      cnt_o          = freq_i;
      addr_o         = '0;
      stopped_o      = 1'b0;
      wave_address_o = '0;
    end else if (!stopped_i) begin
      if (at_end) begin
        half_timing_o = ((addr_i & hmask) == hmask);
        cnt_o         = freq_i;
        // One-shot parks on the last sample; looping keeps counting through
        // the full address space and relies on masking for the wrap.
        if (end_of_wave && oneshot_i) stopped_o = 1'b1;
        else                          addr_o    = addr_i + ADDR_W'(1);
      end else begin
        cnt_o = cnt_i - FREQ_W'(1);
      end
    end
  end
endmodule

// File: rtl/wts_tone_generator_mc.sv
// Time-multiplexed wave-table tone generator: one channel serviced per
// enabled cycle, round-robin over NUM_CH channels.
//   clk    : system clock
//   nreset : asynchronous reset, active low
//   bus    : register inputs, key_on pulses and the registered slot result bus
module wts_tone_generator_mc
  import wts_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int FREQ_W = 12,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  nreset,
  wts_tone_generator_mc_if.slave bus
);
  localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [FREQ_W-1:0] cnt_q  [NUM_CH];
  logic [ADDR_W-1:0] addr_q [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] stopped_q, stopped_d;

  logic              slot_valid_q;
  logic [SLOT_W-1:0] slot_ch_q;
  logic [ADDR_W-1:0] wave_address_q;
  logic              half_timing_q;
  logic [NUM_CH-1:0] active_q;

  logic [SLOT_W-1:0] ch;
  logic [FREQ_W-1:0] freq_s;
  logic [1:0]        mode_s;
  logic              kon_s;
  logic [FREQ_W-1:0] cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W-1:0] wa_n;
  logic              half_n;
  logic              stopped_n;

  always_comb begin
    ch     = slot_q;
    freq_s = bus.reg_frequency_count[ch*FREQ_W +: FREQ_W];
    mode_s = bus.reg_wave_length[ch*2 +: 2];
    // A pulse landing in the channel's own slot is honoured immediately.
    kon_s  = pending_q[ch] | bus.key_on[ch];

    pending_d = pending_q | bus.key_on;
    stopped_d = stopped_q;
    slot_d    = slot_q;
    if (bus.enable) begin
      pending_d[ch] = 1'b0;
      stopped_d[ch] = stopped_n;
      slot_d        = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
    end
  end

  wts_tone_step #(
    .FREQ_W (FREQ_W),
    .ADDR_W (ADDR_W)
  ) u_step (
    .cnt_i          (cnt_q[ch]),
    .addr_i         (addr_q[ch]),
    .freq_i         (freq_s),
    .mode_i         (mode_s),
    .oneshot_i      (bus.reg_oneshot[ch]),
    .key_on_i       (kon_s),
    .stopped_i      (stopped_q[ch]),
    .cnt_o          (cnt_n),
    .addr_o         (addr_n),
    .wave_address_o (wa_n),
    .half_timing_o  (half_n),
    .stopped_o      (stopped_n)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot_q         <= '0;
      pending_q      <= '0;
      stopped_q      <= '1;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= '0;
        addr_q[c] <= '0;
      end
      slot_valid_q   <= 1'b0;
      slot_ch_q      <= '0;
      wave_address_q <= '0;
      half_timing_q  <= 1'b0;
      active_q       <= '0;
    end else begin
      slot_q       <= slot_d;
      pending_q    <= pending_d;
      stopped_q    <= stopped_d;
      slot_valid_q <= bus.enable;
      active_q     <= ~stopped_d;
      if (bus.enable) begin
        cnt_q[ch]      <= cnt_n;
        addr_q[ch]     <= addr_n;
        slot_ch_q      <= ch;
        wave_address_q <= wa_n;
        half_timing_q  <= half_n;
      end
    end
  end

  assign bus.slot_valid   = slot_valid_q;
  assign bus.slot_ch      = slot_ch_q;
  assign bus.wave_address = wave_address_q;
  assign bus.half_timing  = half_timing_q;
  assign bus.active       = active_q;
endmodule
